// File: rtl/pll_sweep_if.sv
// Signal bundle between the BER-bench controller and the PLL sweep sequencer.
// The sequencer takes the slave side; the driving bench or controller takes the master side.
interface pll_sweep_if #(
  parameter int ECW = 16
);
  logic           START;
  logic [3:0]     ADDR_MIN;
  logic [3:0]     ADDR_MAX;
  logic           LOCK;
  logic           ERR;
  logic [3:0]     PLL_ADDR;
  logic           PLL_CHG;
  logic           BUSY;
  logic           MEAS;
  logic           RES_VLD;
  logic [3:0]     RES_ADDR;
  logic [ECW-1:0] RES_ERR;
  logic           RES_TO;
  logic           DONE;

  modport master (
    output START, ADDR_MIN, ADDR_MAX, LOCK, ERR,
    input  PLL_ADDR, PLL_CHG, BUSY, MEAS, RES_VLD, RES_ADDR, RES_ERR, RES_TO, DONE
  );

  modport slave (
    input  START, ADDR_MIN, ADDR_MAX, LOCK, ERR,
    output PLL_ADDR, PLL_CHG, BUSY, MEAS, RES_VLD, RES_ADDR, RES_ERR, RES_TO, DONE
  );
endinterface

// File: rtl/pll_sweep_seq.sv
// Steps the PLL DRP address through a range and measures BER at each point.
// Optional macro PLL_SWEEP_LOOP_EN: restart the sweep at end when START is held.
module pll_sweep_seq #(
  parameter int HOLD_CYC   = 64,
  parameter int TO_CYC     = 65535,
  parameter int SETTLE_CYC = 1024,
  parameter int WIN_CYC    = 65535,
  parameter int ECW        = 16
) (
  input  logic        CLK,
  input  logic        RST,
  pll_sweep_if.slave  bus
);

  localparam int MAX_A   = (HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC;
  localparam int MAX_B   = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHG    = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_LOCKW  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_MEASW  = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     cur_q, cur_d;
  logic [3:0]     min_q, min_d;
  logic [3:0]     max_q, max_d;
  logic [3:0]     pll_addr_q, pll_addr_d;
  logic [ECW-1:0] errcnt_q, errcnt_d;
  logic [3:0]     res_addr_q, res_addr_d;
  logic [ECW-1:0] res_err_q, res_err_d;
  logic           res_to_q, res_to_d;
  logic           lock_meta_q, lock_sync_q;
  logic           go_rep, rep_to, last_pt;

  // An inverted range still measures ADDR_MIN once, then ends.
  assign last_pt = (cur_q == max_q) || (min_q > max_q);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    min_d      = min_q;
    max_d      = max_q;
    pll_addr_d = pll_addr_q;
    errcnt_d   = errcnt_q;
    res_addr_d = res_addr_q;
    res_err_d  = res_err_q;
    res_to_d   = res_to_q;
    go_rep     = 1'b0;
    rep_to     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          min_d      = bus.ADDR_MIN;
          max_d      = bus.ADDR_MAX;
          cur_d      = bus.ADDR_MIN;
          pll_addr_d = bus.ADDR_MIN;
          cnt_d      = '0;
          state_d    = S_CHG;
        end
      end
      S_CHG: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_LOCKW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKW: begin
        if (lock_sync_q) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          go_rep = 1'b1;
          rep_to = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (!lock_sync_q) begin
          go_rep = 1'b1;
          rep_to = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d    = '0;
          errcnt_d = '0;
          state_d  = S_MEASW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEASW: begin
        // Saturating count; the last window cycle's pulse is included via errcnt_d.
        if (bus.ERR && (errcnt_q != '1)) errcnt_d = errcnt_q + ECW'(1);
        if (!lock_sync_q) begin
          go_rep = 1'b1;
          rep_to = 1'b1;
        end else if (cnt_q == WIN_LAST) begin
          go_rep = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPORT: begin
        cnt_d = '0;
        if (last_pt) begin
`ifdef PLL_SWEEP_LOOP_EN
          if (bus.START) begin
            cur_d      = min_q;
            pll_addr_d = min_q;
            state_d    = S_CHG;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cur_d      = cur_q + 4'd1;
          pll_addr_d = cur_q + 4'd1;
          state_d    = S_CHG;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_rep) begin
      cnt_d      = '0;
      res_addr_d = cur_q;
      res_err_d  = rep_to ? '1 : errcnt_d;
      res_to_d   = rep_to;
      state_d    = S_REPORT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      pll_addr_q  <= '0;
      errcnt_q    <= '0;
      res_addr_q  <= '0;
      res_err_q   <= '0;
      res_to_q    <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      min_q       <= min_d;
      max_q       <= max_d;
      pll_addr_q  <= pll_addr_d;
      errcnt_q    <= errcnt_d;
      res_addr_q  <= res_addr_d;
      res_err_q   <= res_err_d;
      res_to_q    <= res_to_d;
      lock_meta_q <= bus.LOCK;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign bus.PLL_ADDR = pll_addr_q;
  assign bus.PLL_CHG  = (state_q == S_CHG);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.MEAS     = (state_q == S_MEASW);
  assign bus.RES_VLD  = (state_q == S_REPORT);
  assign bus.RES_ADDR = res_addr_q;
  assign bus.RES_ERR  = res_err_q;
  assign bus.RES_TO   = res_to_q;
  assign bus.DONE     = (state_q == S_REPORT) && last_pt;

endmodule

// File: tb/tb_pll_sweep_seq.sv
// Directed bench for pll_sweep_seq; a negedge monitor pops expected PLL_CHG addresses and
// result records from queues filled by the stimulus process.
module tb_pll_sweep_seq;
  localparam int HOLD = 4;
  localparam int TO   = 32;
  localparam int SET  = 8;
  localparam int WIN  = 16;
  localparam int ECW  = 4;

  typedef struct packed {
    logic [3:0]     addr;
    logic [ECW-1:0] err;
    logic           to;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_sweep_if #(.ECW(ECW)) bus ();

  pll_sweep_seq #(
    .HOLD_CYC(HOLD), .TO_CYC(TO), .SETTLE_CYC(SET), .WIN_CYC(WIN), .ECW(ECW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  res_t       exp_res[$];
  logic [3:0] exp_chg[$];
  res_t       mon_e;
  logic [3:0] mon_a;
  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, exp_done = 0, meas_run = 0, last_meas = 0, t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.RES_VLD) begin
      if (exp_res.size() == 0) check("res_unexpected", 32'(bus.RES_VLD), 0);
      else begin
        mon_e = exp_res.pop_front();
        check("res_addr", 32'(bus.RES_ADDR), 32'(mon_e.addr));
        check("res_err",  32'(bus.RES_ERR),  32'(mon_e.err));
        check("res_to",   32'(bus.RES_TO),   32'(mon_e.to));
      end
    end
    if (bus.PLL_CHG) begin
      if (exp_chg.size() == 0) check("chg_unexpected", 32'(bus.PLL_CHG), 0);
      else begin
        mon_a = exp_chg.pop_front();
        check("chg_addr", 32'(bus.PLL_ADDR), 32'(mon_a));
      end
    end
    if (bus.DONE) done_cnt++;
    if (bus.MEAS) meas_run++;
    else if (meas_run != 0) begin
      last_meas = meas_run;
      meas_run  = 0;
    end
  end

  function automatic logic sig(input int s);
    case (s)
      0:       return bus.PLL_CHG;
      1:       return bus.MEAS;
      2:       return bus.RES_VLD;
      default: return bus.BUSY;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input string name, input int s, input logic val, input int budget);
    int n = 0;
    while (sig(s) !== val && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(sig(s)), 32'(val));
  endtask

  task automatic start_pulse(input logic [3:0] amin, input logic [3:0] amax);
    bus.ADDR_MIN = amin;
    bus.ADDR_MAX = amax;
    bus.START    = 1'b1;
    step(1);
    bus.START    = 1'b0;
  endtask

  task automatic end_of_sweep(input string name);
    wait_for(name, 3, 1'b0, 400);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("res_queue_empty", 32'(exp_res.size()), 0);
    check("chg_queue_empty", 32'(exp_chg.size()), 0);
  endtask

  initial begin
    bus.START = 1'b0; bus.ADDR_MIN = '0; bus.ADDR_MAX = '0;
    bus.LOCK  = 1'b1; bus.ERR = 1'b0;
    step(3);
    check("rst_pll_addr", 32'(bus.PLL_ADDR), 0);
    check("rst_pll_chg",  32'(bus.PLL_CHG),  0);
    check("rst_busy",     32'(bus.BUSY),     0);
    check("rst_meas",     32'(bus.MEAS),     0);
    check("rst_res_vld",  32'(bus.RES_VLD),  0);
    check("rst_res_err",  32'(bus.RES_ERR),  0);
    check("rst_res_to",   32'(bus.RES_TO),   0);
    check("rst_done",     32'(bus.DONE),     0);
    rst = 1'b0;
    step(2);

    // Sweep 3..5, five in-window errors on point 3, two outside, ignored restart
    exp_chg = '{4'd3, 4'd4, 4'd5};
    exp_res.push_back('{4'd3, 4'd5, 1'b0});
    exp_res.push_back('{4'd4, 4'd0, 1'b0});
    exp_res.push_back('{4'd5, 4'd0, 1'b0});
    exp_done++;
    bus.ADDR_MIN = 4'd3; bus.ADDR_MAX = 4'd5; bus.START = 1'b1;
    step(1);
    check("busy_rise", 32'(bus.BUSY), 1);
    t0 = cyc;
    bus.START = 1'b0; bus.ERR = 1'b1;
    step(1);
    bus.ERR = 1'b0; bus.START = 1'b1; bus.ADDR_MIN = 4'd0; bus.ADDR_MAX = 4'd1;
    step(1);
    bus.START = 1'b0;
    wait_for("meas_rise", 1, 1'b1, 200);
    check("meas_latency", 32'(cyc - t0), 14);
    for (int k = 0; k < 5; k++) begin
      bus.ERR = 1'b1; step(1);
      bus.ERR = 1'b0; step(1);
    end
    wait_for("meas_fall", 1, 1'b0, 100);
    bus.ERR = 1'b1; step(1); bus.ERR = 1'b0;
    end_of_sweep("sweep1_end");
    check("meas_len", 32'(last_meas), 16);

    // Error held through the window saturates the 4-bit count
    exp_chg.push_back(4'd10);
    exp_res.push_back('{4'd10, 4'd15, 1'b0});
    exp_done++;
    bus.ERR = 1'b1;
    start_pulse(4'd10, 4'd10);
    end_of_sweep("sat_end");
    bus.ERR = 1'b0;

    // No lock on point 1: timeout after HOLD+TO, then point 2 locks
    exp_chg = '{4'd1, 4'd2};
    exp_res.push_back('{4'd1, 4'd15, 1'b1});
    exp_res.push_back('{4'd2, 4'd0, 1'b0});
    exp_done++;
    bus.LOCK = 1'b0;
    start_pulse(4'd1, 4'd2);
    t0 = cyc;
    wait_for("to_res", 2, 1'b1, 200);
    check("to_latency", 32'(cyc - t0), 37);
    bus.LOCK = 1'b1;
    end_of_sweep("to_end");

    // Lock lost five cycles into the window
    exp_chg.push_back(4'd6);
    exp_res.push_back('{4'd6, 4'd15, 1'b1});
    exp_done++;
    start_pulse(4'd6, 4'd6);
    wait_for("drop_meas_rise", 1, 1'b1, 200);
    step(5);
    bus.LOCK = 1'b0;
    wait_for("drop_res", 2, 1'b1, 50);
    check("drop_meas_off", 32'(bus.MEAS), 0);
    bus.LOCK = 1'b1;
    end_of_sweep("drop_end");
    check("drop_meas_len", 32'(last_meas), 8);

    // Inverted range measures only ADDR_MIN
    exp_chg.push_back(4'd7);
    exp_res.push_back('{4'd7, 4'd0, 1'b0});
    exp_done++;
    start_pulse(4'd7, 4'd2);
    end_of_sweep("inv_end");

    // Reset in the middle of the window drops everything, no result
    exp_chg.push_back(4'd4);
    start_pulse(4'd4, 4'd4);
    wait_for("rst_meas_rise", 1, 1'b1, 200);
    step(3);
    rst = 1'b1;
    #1;
    check("mrst_meas",     32'(bus.MEAS),     0);
    check("mrst_busy",     32'(bus.BUSY),     0);
    check("mrst_pll_chg",  32'(bus.PLL_CHG),  0);
    check("mrst_pll_addr", 32'(bus.PLL_ADDR), 0);
    check("mrst_res_vld",  32'(bus.RES_VLD),  0);
    step(2);
    rst = 1'b0;
    step(40);
    check("mrst_done", 32'(done_cnt), 32'(exp_done));
    check("mrst_chg_empty", 32'(exp_chg.size()), 0);

    // Recovery sweep after reset, including the top address
    exp_chg = '{4'd14, 4'd15};
    exp_res.push_back('{4'd14, 4'd0, 1'b0});
    exp_res.push_back('{4'd15, 4'd0, 1'b0});
    exp_done++;
    start_pulse(4'd14, 4'd15);
    end_of_sweep("top_end");

`ifdef PLL_SWEEP_LOOP_EN
    // START held at end of sweep restarts at ADDR_MIN without IDLE
    exp_chg = '{4'd9, 4'd9};
    exp_res.push_back('{4'd9, 4'd0, 1'b0});
    exp_res.push_back('{4'd9, 4'd0, 1'b0});
    exp_done += 2;
    bus.ADDR_MIN = 4'd9; bus.ADDR_MAX = 4'd9; bus.START = 1'b1;
    step(1);
    wait_for("loop_res", 2, 1'b1, 200);
    step(1);
    check("loop_chg", 32'(bus.PLL_CHG), 1);
    check("loop_busy", 32'(bus.BUSY), 1);
    bus.START = 1'b0;
    end_of_sweep("loop_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
